// File: rtl/idu_pkg.sv
// Shared types for the decode stage: decoded packet layout, instruction groups, opcodes.
package idu_pkg;

  localparam int INST_DATA_WIDTH = 32;
  localparam int INST_ADDR_WIDTH = 32;
  localparam int REG_ADDR_WIDTH  = 5;
  localparam int CSR_ADDR_WIDTH  = 12;
  localparam int DECINFO_WIDTH   = 8;

  // Instruction group carried in dec_info_bus[3:0]; zero means NOP in EX.
  typedef enum logic [3:0] {
    GRP_NOP     = 4'd0,
    GRP_ALU_IMM = 4'd1,
    GRP_ALU_REG = 4'd2,
    GRP_LUI     = 4'd3,
    GRP_AUIPC   = 4'd4,
    GRP_JAL     = 4'd5,
    GRP_JALR    = 4'd6,
    GRP_BRANCH  = 4'd7,
    GRP_LOAD    = 4'd8,
    GRP_STORE   = 4'd9,
    GRP_CSR     = 4'd10
  } idu_grp_e;

  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  // dec_info_bus layout: {alt (funct7[5] where meaningful), funct3, group}
  typedef struct packed {
    logic [INST_ADDR_WIDTH-1:0] inst_addr;
    logic                       reg_we;
    logic [REG_ADDR_WIDTH-1:0]  reg_waddr;
    logic [REG_ADDR_WIDTH-1:0]  reg1_raddr;
    logic [REG_ADDR_WIDTH-1:0]  reg2_raddr;
    logic                       csr_we;
    logic [CSR_ADDR_WIDTH-1:0]  csr_waddr;
    logic [CSR_ADDR_WIDTH-1:0]  csr_raddr;
    logic [31:0]                dec_imm;
    logic [DECINFO_WIDTH-1:0]   dec_info_bus;
    logic                       is_pred_branch;
  } idu_dec_pkt_t;

  localparam int IDU_PKT_W = $bits(idu_dec_pkt_t);

endpackage

// File: rtl/idu_decode.sv
// Combinational single-instruction decoder producing one idu_dec_pkt_t.
// Emits an all-zero packet while rst_n is low; unknown opcodes decode to NOP.
module idu_decode
  import idu_pkg::*;
(
  input  logic                       rst_n,
  input  logic [INST_DATA_WIDTH-1:0] inst,
  input  logic [INST_ADDR_WIDTH-1:0] inst_addr,
  input  logic                       is_pred_branch,
  output idu_dec_pkt_t               pkt
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  idu_grp_e    grp;
  logic        alt;
  logic [2:0]  f3;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

  // Classify the opcode into an instruction group
  always_comb begin
    case (opcode)
      OPC_OP_IMM: grp = GRP_ALU_IMM;
      OPC_OP:     grp = GRP_ALU_REG;
      OPC_LUI:    grp = GRP_LUI;
      OPC_AUIPC:  grp = GRP_AUIPC;
      OPC_JAL:    grp = GRP_JAL;
      OPC_JALR:   grp = GRP_JALR;
      OPC_BRANCH: grp = GRP_BRANCH;
      OPC_LOAD:   grp = GRP_LOAD;
      OPC_STORE:  grp = GRP_STORE;
      OPC_SYSTEM: grp = (funct3 != 3'b000) ? GRP_CSR : GRP_NOP;
      default:    grp = GRP_NOP;
    endcase
  end

  // Fill packet fields according to the group's operand usage
  always_comb begin
    pkt = '0;
    alt = 1'b0;
    f3  = funct3;
    if (rst_n) begin
      pkt.inst_addr      = inst_addr;
      pkt.is_pred_branch = is_pred_branch;
      case (grp)
        GRP_ALU_IMM: begin
          pkt.reg_we = 1'b1; pkt.reg_waddr = rd; pkt.reg1_raddr = rs1; pkt.dec_imm = imm_i;
          alt = (funct3[1:0] == 2'b01) & inst[30];  // only shifts use funct7[5]
        end
        GRP_ALU_REG: begin
          pkt.reg_we = 1'b1; pkt.reg_waddr = rd; pkt.reg1_raddr = rs1; pkt.reg2_raddr = rs2;
          alt = inst[30];
        end
        GRP_LUI, GRP_AUIPC: begin
          pkt.reg_we = 1'b1; pkt.reg_waddr = rd; pkt.dec_imm = imm_u; f3 = 3'b000;
        end
        GRP_JAL: begin
          pkt.reg_we = 1'b1; pkt.reg_waddr = rd; pkt.dec_imm = imm_j; f3 = 3'b000;
        end
        GRP_JALR, GRP_LOAD: begin
          pkt.reg_we = 1'b1; pkt.reg_waddr = rd; pkt.reg1_raddr = rs1; pkt.dec_imm = imm_i;
        end
        GRP_BRANCH: begin
          pkt.reg1_raddr = rs1; pkt.reg2_raddr = rs2; pkt.dec_imm = imm_b;
        end
        GRP_STORE: begin
          pkt.reg1_raddr = rs1; pkt.reg2_raddr = rs2; pkt.dec_imm = imm_s;
        end
        GRP_CSR: begin
          pkt.reg_we     = 1'b1;
          pkt.reg_waddr  = rd;
          pkt.reg1_raddr = funct3[2] ? 5'd0 : rs1;        // immediate forms carry zimm in rs1
          pkt.dec_imm    = funct3[2] ? {27'b0, rs1} : 32'b0;
          pkt.csr_we     = 1'b1;
          pkt.csr_waddr  = inst[31:20];
          pkt.csr_raddr  = inst[31:20];
        end
        default: f3 = 3'b000;
      endcase
      pkt.dec_info_bus = (grp == GRP_NOP) ? '0 : {alt, f3, grp};
    end
  end

endmodule

// File: rtl/idu_dec_queue.sv
// Multi-lane decode stage feeding an in-order decoded-packet queue towards EX.
// Handshake: an input beat is taken when inst_ready_o & inst_valid_i[0] & !flush_i;
// the head is consumed when out_valid_o & ex_ready_i & !flush_i. inst_ready_o depends
// only on the registered count, so ex_ready_i never reaches it combinationally.
module idu_dec_queue
  import idu_pkg::*;
#(
  parameter int ENQ_W = 2,
  parameter int DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ENQ_W-1:0]                 inst_valid_i,
  input  logic [ENQ_W*INST_DATA_WIDTH-1:0] inst_i,
  input  logic [ENQ_W*INST_ADDR_WIDTH-1:0] inst_addr_i,
  input  logic [ENQ_W-1:0]                 is_pred_branch_i,
  output logic                             inst_ready_o,
  input  logic                             flush_i,
  input  logic                             ex_ready_i,
  output logic                             out_valid_o,
  output logic [INST_ADDR_WIDTH-1:0]       inst_addr_o,
  output logic                             reg_we_o,
  output logic [REG_ADDR_WIDTH-1:0]        reg_waddr_o,
  output logic [REG_ADDR_WIDTH-1:0]        reg1_raddr_o,
  output logic [REG_ADDR_WIDTH-1:0]        reg2_raddr_o,
  output logic                             csr_we_o,
  output logic [CSR_ADDR_WIDTH-1:0]        csr_waddr_o,
  output logic [CSR_ADDR_WIDTH-1:0]        csr_raddr_o,
  output logic [31:0]                      dec_imm_o,
  output logic [DECINFO_WIDTH-1:0]         dec_info_bus_o,
  output logic                             is_pred_branch_o,
  output logic [$clog2(DEPTH+1)-1:0]       count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  if (ENQ_W < 1 || ENQ_W > 2 || DEPTH < 2 || DEPTH < ENQ_W || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
    $error("idu_dec_queue: illegal ENQ_W/DEPTH combination");
  end

  idu_dec_pkt_t       dec_pkt [ENQ_W];
  idu_dec_pkt_t       mem     [DEPTH];
  idu_dec_pkt_t       head;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count, n_enq;
  logic [ENQ_W-1:0]   lane_we;
  logic               inst_ready, out_valid, enq, deq, run;

  for (genvar k = 0; k < ENQ_W; k++) begin : g_lane
    idu_decode u_dec (
      .rst_n          (!rst),
      .inst           (inst_i[k*INST_DATA_WIDTH +: INST_DATA_WIDTH]),
      .inst_addr      (inst_addr_i[k*INST_ADDR_WIDTH +: INST_ADDR_WIDTH]),
      .is_pred_branch (is_pred_branch_i[k]),
      .pkt            (dec_pkt[k])
    );
  end

  assign inst_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(ENQ_W);
  assign out_valid  = (count != '0);
  assign enq        = inst_ready & inst_valid_i[0] & !flush_i;
  assign deq        = out_valid & ex_ready_i & !flush_i;

  // Write only the contiguous run of valid lanes starting at lane 0
  always_comb begin
    run     = 1'b1;
    lane_we = '0;
    n_enq   = '0;
    for (int k = 0; k < ENQ_W; k++) begin
      run = run & inst_valid_i[k];
      if (enq && run) begin
        lane_we[k] = 1'b1;
        n_enq      = n_enq + CNT_W'(1);
      end
    end
  end

  // Pointer and occupancy update; reset beats flush, flush beats enqueue/dequeue
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(n_enq);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      count  <= count + n_enq - CNT_W'(deq);
    end
  end

  // Packet storage; a pair may straddle the last entry and wrap to entry 0
  always_ff @(posedge clk) begin
    for (int k = 0; k < ENQ_W; k++) begin
      if (lane_we[k]) mem[wr_ptr + PTR_W'(k)] <= dec_pkt[k];
    end
  end

  assign head             = out_valid ? mem[rd_ptr] : '0;
  assign inst_ready_o     = inst_ready;
  assign out_valid_o      = out_valid;
  assign count_o          = count;
  assign inst_addr_o      = head.inst_addr;
  assign reg_we_o         = head.reg_we;
  assign reg_waddr_o      = head.reg_waddr;
  assign reg1_raddr_o     = head.reg1_raddr;
  assign reg2_raddr_o     = head.reg2_raddr;
  assign csr_we_o         = head.csr_we;
  assign csr_waddr_o      = head.csr_waddr;
  assign csr_raddr_o      = head.csr_raddr;
  assign dec_imm_o        = head.dec_imm;
  assign dec_info_bus_o   = head.dec_info_bus;
  assign is_pred_branch_o = head.is_pred_branch;

  a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH));
  a_enq_ready:   assert property (@(posedge clk) disable iff (rst) (|lane_we) |-> inst_ready);

endmodule
